// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - fixed-latency single-port data memory controller with clear sweep
module data_memory_ctrl #(
  parameter int WORD_SIZE      = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int MEM_SIZE       = 16,
  parameter int LATENCY        = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_SIZE-1:0]  wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WORD_SIZE-1:0]  rdata
);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]            LAT_LOAD  = 4'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [WORD_SIZE-1:0]  mem [MEM_SIZE];
  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [WORD_SIZE-1:0]  cap_wdata;
  logic                  in_range;

  // Range check works on the captured address so late input changes cannot matter
  assign in_range = {1'b0, cap_addr} < MEM_LIMIT;

  // Controller FSM: clear sweep, accept, latency countdown, execute and respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy     <= (CLEAR_ON_RESET != 0);
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      cnt      <= '0;
      clr_addr <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        CLEAR: begin
          mem[clr_addr] <= '0;
          if (clr_addr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
          end
        end
        IDLE, RESP: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cnt       <= LAT_LOAD;
            state     <= WAIT;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= !in_range;
            if (in_range) begin
              if (cap_we) mem[cap_addr] <= cap_wdata;
              else        rdata         <= mem[cap_addr];
            end else if (!cap_we) begin
              rdata <= '0;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, address width in bits.
REQ-003 The block SHALL have parameter MEM_SIZE, default 16, number of words, legal range 1..2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter LATENCY, default 3, cycles from accept to completion, legal range 1..15.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1, where 1 means memory is zero-filled after reset.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-007 The block SHALL have port req, input, 1 bit: access request, sampled only while busy=0.
REQ-008 The block SHALL have port we, input, 1 bit: 1 means write, 0 means read; qualified by req.
REQ-009 The block SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-010 The block SHALL have port wdata, input, WORD_SIZE bits: write data.
REQ-011 The block SHALL have port busy, output, 1 bit: block is clearing or has an access in flight, so req is ignored.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1 bit: completing access was out of range; valid only with done.
REQ-014 The block SHALL have port rdata, output, WORD_SIZE bits: read result, held until the next read completes.

Function
REQ-015 The FSM SHALL have states CLEAR, IDLE, WAIT and RESP, all registered on posedge clk.
REQ-016 Acceptance SHALL occur at the edge where state=IDLE, busy=0 and req=1; at that edge addr, we and wdata SHALL be captured, state SHALL go to WAIT, and the latency counter SHALL load LATENCY-1.
REQ-017 In WAIT, the counter SHALL decrement each cycle; on the edge where the counter is 0, the access SHALL execute and state SHALL go to RESP.
REQ-018 Timing: for acceptance at edge N, busy SHALL be 1 in the LATENCY cycles after edges N..N+LATENCY-1, and done SHALL be 1 only in the cycle after edge N+LATENCY.
REQ-019 In RESP, busy SHALL be 0 and done SHALL be 1; a req present in that cycle SHALL be accepted at the next edge, giving a peak rate of one access per LATENCY+1 cycles.
REQ-020 req, we, addr and wdata SHALL be ignored while busy=1; requests SHALL NOT be queued; inputs that change after acceptance SHALL NOT affect the access.
REQ-021 Write execution SHALL set memory[addr] to wdata at the execute edge and leave rdata unchanged.
REQ-022 Read execution SHALL load rdata from memory[addr] at the execute edge.
REQ-023 If the captured addr is >= MEM_SIZE, the access SHALL complete with normal timing and err=1, memory SHALL NOT change, and a read SHALL load rdata with 0.
REQ-024 When the execute edge of a write is followed by an accepted read to the same address, the read SHALL return the new data.
REQ-025 In CLEAR, one word per cycle SHALL be zeroed from address 0 to MEM_SIZE-1 with busy=1 and done=0; after the last word, state SHALL go to IDLE.
REQ-026 The CLEAR sweep SHALL take exactly MEM_SIZE cycles.
REQ-027 A req arriving during CLEAR SHALL be ignored.
REQ-028 done and err SHALL be 0 in every state except RESP.

Reset
REQ-029 At an edge with rst=1, state SHALL go to CLEAR if CLEAR_ON_RESET=1, else to IDLE.
REQ-030 At an edge with rst=1, busy SHALL be 1 if CLEAR_ON_RESET=1, else 0.
REQ-031 At an edge with rst=1, done, err, rdata and the counter SHALL be cleared to 0.
REQ-032 rst SHALL take priority over all other inputs.
REQ-033 rst asserted mid-access SHALL abort the in-flight access with no memory write and no done pulse.
REQ-034 rst asserted mid-CLEAR SHALL restart the sweep at address 0.
REQ-035 With CLEAR_ON_RESET=0, memory contents SHALL be unchanged by rst.

Verification (defaults unless stated)
REQ-036 Bench SHALL cover clear then read: rst for 1 cycle -> busy=1 for exactly 16 cycles; then read addr 5 -> done after 3 busy cycles with rdata=0x0000 and err=0.
REQ-037 Bench SHALL cover write then read: write 0xBEEF to addr 3, then read addr 3 issued in the done cycle -> rdata=0xBEEF; accept edges are 4 cycles apart.
REQ-038 Bench SHALL cover busy ignore: req with write 0x1111 to addr 7 while busy -> no extra done pulse, and a later read of addr 7 returns 0x0000.
REQ-039 Bench SHALL cover out of range with MEM_SIZE=12: read addr 13 -> done=1, err=1, rdata=0; write 0xAAAA to addr 12 -> err=1 and no memory change.
REQ-040 Bench SHALL cover reset mid-access: write 0x1234 to addr 2, rst at accept+1 -> no done; after the clear sweep, read addr 2 returns 0x0000.
REQ-041 Bench SHALL cover LATENCY=1 with CLEAR_ON_RESET=0: back-to-back reads -> busy 1 cycle, done 1 cycle, accepts every 2 cycles, and preloaded contents survive rst.
